// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM states and the fixed-priority encoder.
package irq_pkg;

    localparam int unsigned MAX_CH  = 32;
    localparam int unsigned MAX_IDW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] idx;
    } prio_t;

    // Lowest set index wins; channel 0 has the highest priority.
    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] vec);
        prio_t r;
        r = '0;
        for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = MAX_IDW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser per channel plus a rising-edge detector on the synchronised value.
module irq_sync #(
    parameter int unsigned NCH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] irq_in,
    output logic [NCH-1:0] s,
    output logic [NCH-1:0] rise
);

    logic [NCH-1:0] meta_q;
    logic [NCH-1:0] s_q;
    logic [NCH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            s_q    <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= irq_in;
            s_q    <= meta_q;
            prev_q <= s_q;
        end
    end

    assign s    = s_q;
    assign rise = s_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// NCH-channel interrupt controller driving the single IRQ input of the control unit,
// with per-channel edge/level mode, mask, fixed priority and an ack/eret service handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned     NCH        = 8,
    parameter logic [NCH-1:0]  EDGE_MASK  = {NCH{1'b1}},
    parameter logic [NCH-1:0]  MASK_RESET = {NCH{1'b0}},
    parameter int unsigned     IDW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] irq_in,
    input  logic           pc31,
    input  logic           mask_wr,
    input  logic [NCH-1:0] mask_wdata,
    input  logic           irq_ack,
    input  logic           eret,
    input  logic           ovf_clr,
    output logic           irq_req,
    output logic [IDW-1:0] irq_id,
    output logic           in_service,
    output logic [NCH-1:0] mask,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] ovf
);

    logic [NCH-1:0] s;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] rise_e;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] ovf_set;
    prio_t          win;
    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] id_d;

    irq_sync #(.NCH(NCH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .s      (s),
        .rise   (rise)
    );

    // Edge channels use the stored bit; level channels follow the synchronised source.
    assign rise_e  = rise & EDGE_MASK;
    assign pending = (pend_q & EDGE_MASK) | (s & ~EDGE_MASK);
    assign elig    = pending & mask;
    assign win     = prio_enc(MAX_CH'(elig));
    assign clr     = ((state_q == REQ) && irq_ack) ? (NCH'(1) << irq_id) : '0;
    assign ovf_set = rise_e & pend_q & ~clr;

    always_comb begin
        state_d = state_q;
        id_d    = irq_id;
        case (state_q)
            IDLE: begin
                if (win.valid && !pc31) begin
                    state_d = REQ;
                    id_d    = IDW'(win.idx);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                end else if (!elig[irq_id]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_id     <= '0;
            irq_req    <= 1'b0;
            in_service <= 1'b0;
            mask       <= MASK_RESET;
            pend_q     <= '0;
            ovf        <= '0;
        end else begin
            state_q    <= state_d;
            irq_id     <= id_d;
            irq_req    <= (state_d == REQ);
            in_service <= (state_d == SERVICE);
            if (mask_wr) begin
                mask <= mask_wdata;
            end
            // A new edge in the ack cycle keeps the bit set.
            pend_q <= (pend_q & ~clr) | rise_e;
            ovf    <= ovf_clr ? ovf_set : (ovf | ovf_set);
        end
    end

endmodule
